sdr_arb: RTL

SDR_ARB -- requirements
Module: sdr_arb

---
 rtl/sdr_arb_if.sv | 29 ++
 rtl/sdr_arb.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/sdr_arb_if.sv
// Handshake bundle between the SDRAM arbiter, its two host ports, the refresh
// timer and the command sequencer.
interface sdr_arb_if;
    logic       init_done;
    logic       ref_set;
    logic       ref_end;
    logic       req0;
    logic       req1;
    logic       req0_wr_n;
    logic       req1_wr_n;
    logic       cmd_done;
    logic [1:0] gnt;
    logic       ack0;
    logic       ack1;
    logic       sdr_req;
    logic       sdr_req_wr_n;
    logic       StRef;
    logic       tout_err;

    modport slave (
        input  init_done, ref_set, ref_end, req0, req1, req0_wr_n, req1_wr_n, cmd_done,
        output gnt, ack0, ack1, sdr_req, sdr_req_wr_n, StRef, tout_err
    );

    modport master (
        output init_done, ref_set, ref_end, req0, req1, req0_wr_n, req1_wr_n, cmd_done,
        input  gnt, ack0, ack1, sdr_req, sdr_req_wr_n, StRef, tout_err
    );
endinterface

// File: rtl/sdr_arb.sv
// SDR_ARB: two-port SDRAM access arbiter with refresh priority and an access watchdog.
// Define SDR_ARB_FIXED_PRIO_EN to make port 0 always win instead of round-robin.
module sdr_arb #(
    parameter int TOUT_W = 8
) (
    input  logic     mclk,
    input  logic     s_reset,
    sdr_arb_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2,
        REF   = 2'd3
    } state_t;

    localparam logic [TOUT_W-1:0] WD_ZERO = {TOUT_W{1'b0}};
    localparam logic [TOUT_W-1:0] WD_MAX  = {TOUT_W{1'b1}};
    localparam logic [TOUT_W-1:0] WD_ONE  = TOUT_W'(1'b1);
    localparam logic [TOUT_W-1:0] WD_LAST = WD_MAX - WD_ONE;

    state_t            state_r;
    logic [1:0]        gnt_r;
    logic              ack0_r;
    logic              ack1_r;
    logic              sdr_req_r;
    logic              sdr_req_wr_n_r;
    logic              st_ref_r;
    logic              tout_err_r;
    logic [TOUT_W-1:0] wd_r;
`ifndef SDR_ARB_FIXED_PRIO_EN
    logic              last_r;
`endif

    logic want0_s;
    logic want1_s;
    logic pick_valid_s;
    logic pick_port_s;

    // Port selection; a port whose ack is high this cycle is not eligible.
    always_comb begin
        want0_s      = bus.req0 & ~ack0_r;
        want1_s      = bus.req1 & ~ack1_r;
        pick_valid_s = want0_s | want1_s;
`ifdef SDR_ARB_FIXED_PRIO_EN
        if (want0_s) begin
            pick_port_s = 1'b0;
        end else begin
            pick_port_s = 1'b1;
        end
`else
        if (want0_s && want1_s) begin
            pick_port_s = ~last_r;
        end else if (want0_s) begin
            pick_port_s = 1'b0;
        end else begin
            pick_port_s = 1'b1;
        end
`endif
    end

    // Arbitration FSM with registered outputs and access watchdog.
    always_ff @(posedge mclk or posedge s_reset) begin
        if (s_reset) begin
            state_r        <= IDLE;
            gnt_r          <= 2'b00;
            ack0_r         <= 1'b0;
            ack1_r         <= 1'b0;
            sdr_req_r      <= 1'b0;
            sdr_req_wr_n_r <= 1'b0;
            st_ref_r       <= 1'b0;
            tout_err_r     <= 1'b0;
            wd_r           <= WD_ZERO;
`ifndef SDR_ARB_FIXED_PRIO_EN
            last_r         <= 1'b1;
`endif
        end else begin
            ack0_r     <= 1'b0;
            ack1_r     <= 1'b0;
            tout_err_r <= 1'b0;
            if (!bus.init_done) begin
                state_r        <= IDLE;
                gnt_r          <= 2'b00;
                sdr_req_r      <= 1'b0;
                sdr_req_wr_n_r <= 1'b0;
                st_ref_r       <= 1'b0;
                wd_r           <= WD_ZERO;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (bus.ref_set) begin
                            state_r  <= REF;
                            st_ref_r <= 1'b1;
                        end else if (pick_valid_s) begin
                            state_r        <= GRANT;
                            gnt_r          <= pick_port_s ? 2'b10 : 2'b01;
                            sdr_req_r      <= 1'b1;
                            sdr_req_wr_n_r <= pick_port_s ? bus.req1_wr_n : bus.req0_wr_n;
                            wd_r           <= WD_ZERO;
                        end
                    end
                    GRANT: begin
                        state_r <= WAIT;
                    end
                    WAIT: begin
                        if (bus.cmd_done) begin
                            ack0_r    <= gnt_r[0];
                            ack1_r    <= gnt_r[1];
                            gnt_r     <= 2'b00;
                            sdr_req_r <= 1'b0;
`ifndef SDR_ARB_FIXED_PRIO_EN
                            last_r    <= gnt_r[1];
`endif
                            state_r   <= IDLE;
                        end else if (wd_r == WD_LAST) begin
                            // Count reaches all-ones: abandon the access without an ack.
                            tout_err_r <= 1'b1;
                            gnt_r      <= 2'b00;
                            sdr_req_r  <= 1'b0;
                            wd_r       <= WD_MAX;
                            state_r    <= IDLE;
                        end else if (wd_r != WD_MAX) begin
                            wd_r <= wd_r + WD_ONE;
                        end
                    end
                    REF: begin
                        if (bus.ref_end) begin
                            st_ref_r <= 1'b0;
                            state_r  <= IDLE;
                        end
                    end
                    default: begin
                        state_r   <= IDLE;
                        gnt_r     <= 2'b00;
                        sdr_req_r <= 1'b0;
                        st_ref_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.gnt          = gnt_r;
    assign bus.ack0         = ack0_r;
    assign bus.ack1         = ack1_r;
    assign bus.sdr_req      = sdr_req_r;
    assign bus.sdr_req_wr_n = sdr_req_wr_n_r;
    assign bus.StRef        = st_ref_r;
    assign bus.tout_err     = tout_err_r;
endmodule
